pe3x3_psum_acc: RTL and testbench

- Sits directly downstream of the 3x3 row PE. It consumes the PE's 9 partial-sum lanes and accumulates them across the 3 kernel rows and all input channels of one output tile.
- When a group completes, it presents the 9 accumulated Q24.8 sums to the output writer through a valid/ready interface with backpressure.
- Holds one group in progress and one completed result, so the PE only stalls when the writer is not ready.

---
 rtl/pe3x3_psum_acc.sv | 88 ++++++++
 tb/tb_pe3x3_psum_acc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe3x3_psum_acc.sv
// Partial-sum accumulator behind the 3x3 row PE: sums 9 Q24.8 lanes over one
// group of beats and hands the finished group to the output writer.
module pe3x3_psum_acc #(
  parameter int OUTPUT_NUM = 9,
  parameter int IW         = 24,
  parameter int FW         = 8,
  parameter int ACC_LEN    = 48,
  localparam int LW        = IW + FW,
  localparam int PW        = OUTPUT_NUM * LW,
  localparam int CW        = $clog2(ACC_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] psum_i,
  input  logic          psum_valid_i,
  input  logic          psum_last_i,
  output logic          psum_ready_o,
  output logic [PW-1:0] res_o,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [CW-1:0] beat_cnt_o,
  output logic          err_o
);

  // Handshake: a beat moves when psum_valid_i && psum_ready_o; a result moves
  // when res_valid_o && res_ready_i. A pending result blocks new beats unless
  // it is being taken in the same cycle, which keeps one group per cycle.
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_res;
  logic          r_res_valid;
  logic [CW-1:0] r_beat_cnt;
  logic          r_err;

  logic          w_accept;
  logic          w_take;
  logic          w_close;
  logic          w_first;
  logic [PW-1:0] w_sum;

  assign psum_ready_o = !r_res_valid || res_ready_i;
  assign w_accept     = psum_valid_i && psum_ready_o;
  assign w_take       = r_res_valid && res_ready_i;
  assign w_first      = (r_beat_cnt == '0);
  assign w_close      = psum_last_i || (r_beat_cnt == CW'(ACC_LEN - 1));

  // Lanes are independent two's-complement adders that wrap.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < OUTPUT_NUM; k++) begin
      w_sum[k*LW +: LW] = w_first ? psum_i[k*LW +: LW]
                                  : r_acc[k*LW +: LW] + psum_i[k*LW +: LW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_take) begin
        r_res_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_close) begin
          r_res       <= w_sum;
          r_res_valid <= 1'b1;
          r_acc       <= '0;
          r_beat_cnt  <= '0;
          if (!psum_last_i) begin
            r_err <= 1'b1;
          end
        end else begin
          r_acc      <= w_sum;
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign res_o       = r_res;
  assign res_valid_o = r_res_valid;
  assign beat_cnt_o  = r_beat_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_pe3x3_psum_acc.sv
// Bench for pe3x3_psum_acc: directed scenarios then random traffic, all checked
// against a group-level reference model with an expected-result queue.
module tb_pe3x3_psum_acc;

  localparam int N       = 9;
  localparam int LW      = 32;
  localparam int PW      = N * LW;
  localparam int ACC_LEN = 48;
  localparam int CW      = $clog2(ACC_LEN + 1);

  logic          clk;
  logic          rst;
  logic [PW-1:0] psum_i;
  logic          psum_valid_i;
  logic          psum_last_i;
  logic          psum_ready_o;
  logic [PW-1:0] res_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [CW-1:0] beat_cnt_o;
  logic          err_o;

  pe3x3_psum_acc #(.OUTPUT_NUM(N), .IW(24), .FW(8), .ACC_LEN(ACC_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .psum_i       (psum_i),
    .psum_valid_i (psum_valid_i),
    .psum_last_i  (psum_last_i),
    .psum_ready_o (psum_ready_o),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .beat_cnt_o   (beat_cnt_o),
    .err_o        (err_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  int            n_chk = 0;
  int            n_err = 0;
  logic [PW-1:0] exp_q[$];

  // reference model: running lane sums, beats in group, pending result, error
  logic [LW-1:0] m_acc [N];
  int            m_cnt;
  logic [PW-1:0] m_res;
  logic          m_res_valid;
  logic          m_err;
  logic          m_last_accepted;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] fill(input logic [LW-1:0] v);
    logic [PW-1:0] p;
    for (int k = 0; k < N; k++) p[k*LW +: LW] = v;
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_acc[k] = '0;
    m_cnt           = 0;
    m_res           = '0;
    m_res_valid     = 1'b0;
    m_err           = 1'b0;
    m_last_accepted = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, ":res_valid"}, PW'(res_valid_o), PW'(m_res_valid));
    check({tag, ":res"},       res_o,            m_res);
    check({tag, ":beat_cnt"},  PW'(beat_cnt_o),  PW'(m_cnt));
    check({tag, ":err"},       PW'(err_o),       PW'(m_err));
  endtask

  // One clock of traffic: drive, check ready, advance the model, check after the edge.
  task automatic step(input logic v, input logic l, input logic rdy, input logic [PW-1:0] p);
    logic          exp_rdy;
    logic          acc;
    logic [PW-1:0] sum;
    psum_valid_i = v;
    psum_last_i  = l;
    res_ready_i  = rdy;
    psum_i       = p;
    #1;
    exp_rdy = !m_res_valid || rdy;
    check("psum_ready", PW'(psum_ready_o), PW'(exp_rdy));
    acc = v && exp_rdy;
    if (m_res_valid && rdy) begin
      if (exp_q.size() == 0) check("take_q_empty", PW'(0), PW'(1));
      else check("taken_result", res_o, exp_q.pop_front());
      m_res_valid = 1'b0;
    end
    if (acc) begin
      for (int k = 0; k < N; k++)
        sum[k*LW +: LW] = (m_cnt == 0) ? p[k*LW +: LW] : m_acc[k] + p[k*LW +: LW];
      if (l || m_cnt == ACC_LEN - 1) begin
        m_res       = sum;
        m_res_valid = 1'b1;
        exp_q.push_back(sum);
        for (int k = 0; k < N; k++) m_acc[k] = '0;
        m_cnt = 0;
        if (!l) m_err = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) m_acc[k] = sum[k*LW +: LW];
        m_cnt++;
      end
    end
    m_last_accepted = acc || !v;
    @(posedge clk);
    #1;
    check_state("step");
  endtask

  task automatic async_reset();
    psum_valid_i = 1'b0;
    psum_last_i  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] p;
    logic          v;
    logic          l;
    rst          = 1'b1;
    psum_i       = '0;
    psum_valid_i = 1'b0;
    psum_last_i  = 1'b0;
    res_ready_i  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;

    // three beats of 1.0 with writer ready, then drain
    step(1, 0, 1, fill(32'h100));
    step(1, 0, 1, fill(32'h100));
    step(1, 1, 1, fill(32'h100));
    check("sum3_lane", res_o[8*LW +: LW], 32'h300);
    step(0, 0, 1, '0);

    // signed wrap on lanes 0 and 1
    p = fill(32'h0);
    p[0 +: LW] = 32'h7FFFFF00;
    p[LW +: LW] = 32'hFFFFFF00;
    step(1, 0, 1, p);
    p[0 +: LW] = 32'h00000100;
    p[LW +: LW] = 32'h00000080;
    step(1, 1, 1, p);
    check("wrap_lane0", res_o[0 +: LW], 32'h80000000);
    check("wrap_lane1", res_o[LW +: LW], 32'hFFFFFF80);
    step(0, 0, 1, '0);

    // backpressure, then take and close in the same cycle
    step(1, 1, 0, fill(32'h100));
    step(1, 1, 0, fill(32'h200));
    step(1, 1, 0, fill(32'h200));
    check("bp_hold", res_o, fill(32'h100));
    step(1, 1, 1, fill(32'h200));
    check("bp_new", res_o, fill(32'h200));
    step(0, 0, 1, '0);

    // overrun forces a close and sets the sticky error
    for (int i = 0; i < ACC_LEN; i++) step(1, 0, 1, fill(32'h1));
    check("overrun_sum", res_o, fill(32'h30));
    check("overrun_err", PW'(err_o), PW'(1));
    step(1, 0, 1, fill(32'h7));
    step(1, 1, 1, fill(32'h9));
    check("err_sticky", PW'(err_o), PW'(1));
    step(0, 0, 1, '0);

    // asynchronous reset in the middle of a group
    step(1, 0, 0, fill(32'h100));
    step(1, 0, 0, fill(32'h100));
    async_reset();
    step(1, 1, 1, fill(32'h55));
    check("post_rst", res_o, fill(32'h55));
    step(0, 0, 1, '0);

    // bubbles inside a group, last flag ignored without valid
    step(1, 0, 1, fill(32'h10));
    step(0, 1, 1, fill(32'hDEAD));
    step(0, 0, 1, '0);
    step(1, 1, 1, fill(32'h20));
    check("bubble_sum", res_o, fill(32'h30));
    step(0, 0, 1, '0);

    // random traffic; an unaccepted beat is held stable
    v = 1'b0;
    l = 1'b0;
    p = '0;
    for (int i = 0; i < 3000; i++) begin
      if (m_last_accepted) begin
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 4) == 0);
        for (int k = 0; k < N; k++) p[k*LW +: LW] = $urandom;
      end
      step(v, l, ($urandom_range(0, 4) < 3), p);
    end
    while (!m_last_accepted) step(v, l, 1'b1, p);
    step(0, 0, 1, '0);
    check("queue_drained", PW'(exp_q.size()), PW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
